// File: rtl/st_event_scheduler.sv
// st_event_scheduler: timestamps detector edges, rate-limits them and queues one event per cycle round-robin
module st_event_scheduler #(
  parameter int NCH     = 4,
  parameter int TS_W    = 16,
  parameter int HOLDOFF = 1000,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         det_in,
  input  logic                   clr,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [$clog2(NCH)-1:0] ev_chan,
  output logic [TS_W-1:0]        ev_ts,
  output logic                   ev_ovf,
  output logic [NCH-1:0]         fault_flag,
  output logic [7:0]             drop_cnt
);
  localparam int CW = $clog2(NCH);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + TS_W + 1;

  logic [TS_W-1:0] ts;
  logic [NCH-1:0]  det_q, pend, ovf, rise, gsel, merge;
  logic [TS_W-1:0] ts_c [NCH];
  logic [HW-1:0]   hold [NCH];
  logic [CW-1:0]   nxt, gidx;
  logic            gnt, full, pop;
  logic [8:0]      drop_sum;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   push_d, head_n;
  logic [AW-1:0]   rd, wr, rd_n;
  logic [AW:0]     cnt, cnt_n;

  assign rise     = det_in & ~det_q;
  assign full     = cnt == (AW+1)'(DEPTH);
  assign pop      = ev_valid & ev_ready;
  assign gsel     = gnt ? NCH'(1) << gidx : '0;
  assign merge    = rise & pend & ~gsel;
  assign drop_sum = {1'b0, drop_cnt} + 9'($countones(merge));
  assign push_d   = {gidx, ts_c[gidx], ovf[gidx]};
  assign rd_n     = rd + AW'(pop);
  assign cnt_n    = cnt + (AW+1)'(gnt) - (AW+1)'(pop);
  assign head_n   = cnt == (AW+1)'(pop) ? push_d : mem[rd_n];

  // Round-robin pick: scan from the far end so the channel nearest nxt wins
  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (pend[(int'(nxt) + k) % NCH] && !full && !clr) begin
        gnt  = 1'b1;
        gidx = CW'((int'(nxt) + k) % NCH);
      end
  end

  // Per-channel capture, merge and holdoff state; a channel in its grant cycle ignores its own rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts         <= '0;
      det_q      <= '0;
      pend       <= '0;
      ovf        <= '0;
      nxt        <= '0;
      fault_flag <= '0;
      drop_cnt   <= '0;
      for (int i = 0; i < NCH; i++) begin
        ts_c[i] <= '0;
        hold[i] <= '0;
      end
    end else begin
      ts    <= ts + 1'b1;
      det_q <= det_in;
      if (clr) begin
        pend       <= '0;
        ovf        <= '0;
        fault_flag <= '0;
        drop_cnt   <= '0;
        for (int i = 0; i < NCH; i++) hold[i] <= '0;
      end else begin
        fault_flag <= fault_flag | rise;
        drop_cnt   <= drop_sum[8] ? 8'hff : drop_sum[7:0];
        if (gnt) nxt <= CW'((int'(gidx) + 1) % NCH);
        for (int i = 0; i < NCH; i++)
          if (gsel[i]) begin
            pend[i] <= 1'b0;
            hold[i] <= HW'(HOLDOFF);
          end else if (hold[i] != '0) hold[i] <= hold[i] - 1'b1;
          else if (rise[i] && pend[i]) ovf[i] <= 1'b1;
          else if (rise[i]) begin
            pend[i] <= 1'b1;
            ts_c[i] <= ts;
            ovf[i]  <= 1'b0;
          end
      end
    end

  // Event FIFO with a registered head that keeps its last contents while empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
      ev_valid <= 1'b0;
      ev_chan  <= '0;
      ev_ts    <= '0;
      ev_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
      ev_valid <= 1'b0;
    end else begin
      if (gnt) begin
        mem[wr] <= push_d;
        wr      <= wr + 1'b1;
      end
      rd       <= rd_n;
      cnt      <= cnt_n;
      ev_valid <= cnt_n != '0;
      if (cnt_n != '0) {ev_chan, ev_ts, ev_ovf} <= head_n;
    end
endmodule

// File: tb/tb_st_event_scheduler.sv
// tb_st_event_scheduler: directed and random checks of the event scheduler against a queue-based model
module tb_st_event_scheduler;
  localparam int NCH = 4, TS_W = 16, HOLDOFF = 50, DEPTH = 8;

  logic           clk = 1'b0, rst_n = 1'b0, clr = 1'b0, ev_ready = 1'b0;
  logic [NCH-1:0] det_in = '0;
  logic           ev_valid, ev_ovf;
  logic [1:0]     ev_chan;
  logic [15:0]    ev_ts;
  logic [3:0]     fault_flag;
  logic [7:0]     drop_cnt;
  int             checks = 0, errors = 0;

  always #5 clk = ~clk;

  st_event_scheduler #(.NCH(NCH), .TS_W(TS_W), .HOLDOFF(HOLDOFF), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .det_in(det_in), .clr(clr), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_chan(ev_chan), .ev_ts(ev_ts), .ev_ovf(ev_ovf), .fault_flag(fault_flag), .drop_cnt(drop_cnt)
  );

  typedef struct { int chan; int ts; bit ovf; } ev_t;
  ev_t            q[$];
  ev_t            head;
  int             m_ts, m_nxt, m_drop, m_cyc;
  bit             m_pend [NCH];
  bit             m_ovf  [NCH];
  int             m_tsc  [NCH];
  int             m_hold [NCH];
  int             m_gcyc [NCH];
  bit [NCH-1:0]   m_detq, m_ff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    head.chan = 0; head.ts = 0; head.ovf = 0;
    m_ts = 0; m_nxt = 0; m_drop = 0; m_detq = '0; m_ff = '0;
    for (int c = 0; c < NCH; c++) begin
      m_pend[c] = 0; m_ovf[c] = 0; m_tsc[c] = 0; m_hold[c] = 0; m_gcyc[c] = -1000;
    end
  endfunction

  function automatic void model_step();
    int g, c;
    bit [NCH-1:0] rise;
    ev_t e;
    g = -1;
    rise = det_in & ~m_detq;
    if (!clr && q.size() < DEPTH)
      for (int k = 0; k < NCH; k++) begin
        c = (m_nxt + k) % NCH;
        if (g < 0 && m_pend[c]) g = c;
      end
    if (clr) begin
      q.delete();
      m_ff = '0; m_drop = 0;
      for (int i = 0; i < NCH; i++) begin m_pend[i] = 0; m_ovf[i] = 0; m_hold[i] = 0; end
    end else begin
      if (q.size() > 0 && ev_ready) void'(q.pop_front());
      if (g >= 0) begin
        e.chan = g; e.ts = m_tsc[g]; e.ovf = m_ovf[g];
        q.push_back(e);
        m_pend[g] = 0; m_nxt = (g + 1) % NCH; m_gcyc[g] = m_cyc;
      end
      m_ff = m_ff | rise;
      for (int i = 0; i < NCH; i++)
        if (i == g) m_hold[i] = HOLDOFF;
        else if (m_hold[i] > 0) m_hold[i]--;
        else if (rise[i] && m_pend[i]) begin
          m_ovf[i] = 1;
          if (m_drop < 255) m_drop++;
        end else if (rise[i]) begin
          m_pend[i] = 1; m_tsc[i] = m_ts; m_ovf[i] = 0;
        end
    end
    m_detq = det_in;
    m_ts = (m_ts + 1) % 65536;
    m_cyc++;
    if (q.size() > 0) head = q[0];
  endfunction

  task automatic compare_all();
    chk("ev_valid", ev_valid, q.size() > 0);
    chk("ev_chan", ev_chan, head.chan);
    chk("ev_ts", ev_ts, head.ts);
    chk("ev_ovf", ev_ovf, head.ovf);
    chk("fault_flag", fault_flag, m_ff);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, ev_valid, 0);
    chk({tag, "_chan"}, ev_chan, 0);
    chk({tag, "_ts"}, ev_ts, 0);
    chk({tag, "_ovf"}, ev_ovf, 0);
    chk({tag, "_flag"}, fault_flag, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; det_in = '0; clr = 1'b0; ev_ready = 1'b0;
    #1;
    model_reset();
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ts, n;
    bit found;
    int exp4[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    m_cyc = 0;
    do_reset();
    // single pulse on ch2 at ts=10
    while (m_ts != 10) tick();
    det_in = 4'b0100;
    tick();
    chk("t1_not_yet", ev_valid, 0);
    det_in = '0;
    tick();
    chk("t1_valid", ev_valid, 1);
    chk("t1_chan", ev_chan, 2);
    chk("t1_ts", ev_ts, 10);
    chk("t1_ovf", ev_ovf, 0);
    chk("t1_flag", fault_flag, 4'b0100);
    ev_ready = 1'b1;
    repeat (2) tick();
    chk("t1_empty", ev_valid, 0);
    chk("t1_hold_chan", ev_chan, 2);
    // all four channels together, then ch0 and ch3
    do_reset();
    ev_ready = 1'b1;
    det_in = 4'hF;
    tick();
    det_in = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", ev_valid, 1);
      chk("t2_order", ev_chan, i);
      tick();
    end
    chk("t2_drained", ev_valid, 0);
    repeat (HOLDOFF + 5) tick();
    det_in = 4'b1001;
    tick();
    det_in = '0;
    tick();
    chk("t2_rr_first", ev_chan, 0);
    tick();
    chk("t2_rr_second", ev_chan, 3);
    // merging while the FIFO is full, then holdoff discard
    ev_ready = 1'b0;
    repeat (HOLDOFF + 5) tick();
    det_in = 4'hF; tick(); det_in = '0;
    repeat (HOLDOFF + 5) tick();
    det_in = 4'hF; tick(); det_in = '0;
    repeat (HOLDOFF + 5) tick();
    chk("t3_full", ev_valid, 1);
    exp_ts = m_ts;
    repeat (3) begin
      det_in = 4'b0010; tick();
      det_in = '0; tick();
    end
    chk("t3_drop", drop_cnt, 2);
    ev_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (ev_valid && ev_ovf) found = 1;
    end
    chk("t3_found", found, 1);
    chk("t3_chan", ev_chan, 1);
    chk("t3_ts", ev_ts, exp_ts);
    for (int k = 0; k < 40 && m_cyc < m_gcyc[1] + 10; k++) tick();
    det_in = 4'b0010;
    tick();
    det_in = '0;
    repeat (20) tick();
    chk("t3_holdoff_noevent", ev_valid, 0);
    chk("t3_holdoff_flag", fault_flag[1], 1);
    chk("t3_holdoff_drop", drop_cnt, 2);
    // nine events into an eight-deep FIFO
    do_reset();
    det_in = 4'hF; tick(); det_in = '0;
    repeat (HOLDOFF + 5) tick();
    det_in = 4'hF; tick(); det_in = '0;
    repeat (HOLDOFF + 5) tick();
    det_in = 4'b0001; tick(); det_in = '0;
    repeat (5) tick();
    chk("t4_full_valid", ev_valid, 1);
    chk("t4_ninth_waits", q.size(), DEPTH);
    ev_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 9; k++) begin
      if (ev_valid) begin
        chk("t4_order", ev_chan, exp4[n]);
        n++;
      end
      tick();
    end
    chk("t4_count", n, 9);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      det_in = NCH'($urandom & $urandom);
      ev_ready = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 99) == 0;
      tick();
    end
    det_in = '0; clr = 1'b0; ev_ready = 1'b1;
    // timestamp wrap
    while (m_ts != 65400) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    while (m_ts != 65535) tick();
    det_in = 4'b0001; tick();
    det_in = 4'b0010; tick();
    chk("t5_chan_a", ev_chan, 0);
    chk("t5_ts_max", ev_ts, 65535);
    det_in = '0; tick();
    chk("t5_chan_b", ev_chan, 1);
    chk("t5_ts_zero", ev_ts, 0);
    // clr with queued events, then async reset mid-drain
    do_reset();
    det_in = 4'hF; tick();
    det_in = '0; tick();
    det_in = 4'b1000; tick();
    det_in = '0;
    repeat (4) tick();
    repeat (HOLDOFF + 5) tick();
    det_in = 4'b0001; tick(); det_in = '0;
    repeat (3) tick();
    chk("t6_queued", q.size(), 5);
    chk("t6_pre_drop", drop_cnt, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t6_clr_valid", ev_valid, 0);
    chk("t6_clr_flag", fault_flag, 0);
    chk("t6_clr_drop", drop_cnt, 0);
    ev_ready = 1'b1;
    det_in = 4'hF; tick();
    det_in = '0;
    repeat (3) tick();
    chk("t6_draining", ev_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("t6_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
